mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I datapath's memory port: mem_read/mem_write, mem_address, mem_wdata, mem_byte_enable in; mem_rdata, mem_resp out.
- Services one word-wide request at a time from an internal word array after a programmable latency.
- Stands in for the memory model/cache behind the CPU's instruction-fetch, load and store states, which hold a request until mem_resp.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from first cycle a request is visible to the mem_resp cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  read request; held by the initiator until mem_resp.
- mem_write  in  1  write request; held by the initiator until mem_resp.
- mem_address  in  32  byte address; [1:0] ignored, word index = mem_address[log2(DEPTH_WORDS)+1:2].
- mem_wdata  in  32  write data, byte lanes aligned to address bits.
- mem_byte_enable  in  4  write lane mask; ignored for reads.
- mem_rdata  out  32  full read word, valid in the mem_resp cycle.
- mem_resp  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, async): state IDLE, mem_resp=0, mem_rdata=0, latency counter=0, latched request cleared. Array contents are not reset.
- Reset mid-operation: the pending request is abandoned. A write that has not reached its commit edge is not committed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with mem_read|mem_write high, latch address, wdata, byte_enable and op.
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with counter=LATENCY-1.
- WAIT: counter decrements each edge. When counter==1, go to RESP.
- Inputs during WAIT/RESP are ignored; the latched copy is used.
- Timing: request first high in cycle 0 gives mem_resp=1 exactly in cycle LATENCY, for one cycle.
- Commit edge (edge entering RESP):
  - Read: mem_rdata <= array[index].
  - Write: array[index] byte k <= mem_wdata byte k for each set mem_byte_enable[k]; other bytes unchanged.
- mem_rdata holds its value until the next read commit. Writes do not change mem_rdata.
- RESP: mem_resp=1, then unconditionally go to IDLE.
- The initiator deasserts its request in the cycle after mem_resp. A request still high in that first IDLE cycle is a new request (back-to-back allowed, minimum spacing LATENCY+1 cycles).
- Read-after-write: a read accepted after a write's RESP returns the written data.
- Simultaneous mem_read and mem_write: treated as a write. The read is not performed and mem_rdata is unchanged.
- Out-of-range address (mem_address >= 4*DEPTH_WORDS): read returns 0 into mem_rdata; write is dropped; mem_resp still issued normally.
- Request withdrawn before mem_resp: the transaction still completes with the latched values and mem_resp still pulses.
- Byte enable 4'b0000 on a write: no array change, normal mem_resp.

Optional Feature:
- Macro MEMRSP_ERR_EN.
- When defined:
  - Adds output mem_err (1 bit, reset 0).
  - mem_err is high only in the mem_resp cycle of a transaction that had an out-of-range address, read+write both asserted, or a write with byte_enable==0.
  - A $error is also issued in simulation.
- When undefined: no mem_err port; these cases are handled silently as in Behaviour.

Test Plan:
- Reset, then write 32'hDEADBEEF to 0x10 with be=4'hF, LATENCY=2 -> mem_resp high only in cycle 2. Read 0x10 -> mem_rdata=32'hDEADBEEF in its resp cycle.
- Preload 0x20=32'h11223344, then sb 32'h0000AA00 with be=4'b0010 -> read 0x20 returns 32'h1122AA44. Then sh be=4'b1100 wdata 32'h55660000 -> 32'h5566AA44.
- LATENCY=1 and LATENCY=5 builds -> resp in cycle 1 and cycle 5 respectively. Back-to-back reads held high after resp -> resp pulses spaced LATENCY+1 cycles.
- Address changed to 0x44 during WAIT of a read of 0x40 -> returns word at 0x40.
- Read 0x4000 with DEPTH_WORDS=1024 -> mem_rdata=0, resp normal. Write there, then read 0x0 -> word 0 unchanged. With MEMRSP_ERR_EN, mem_err=1 in both resp cycles.
- rst_n low during WAIT of a write to 0x8 -> mem_resp never pulses; a later read of 0x8 returns the old value. rst_n asserted asynchronously mid-cycle -> mem_resp=0 immediately.

Source files
------------

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: single-outstanding word memory behind the CPU memory port.
// Latency: mem_resp pulses exactly LATENCY cycles after a request first appears.
// Backpressure: none; the initiator holds its request until mem_resp, inputs ignored while busy.
// Optional: define MEMRSP_ERR_EN to add the mem_err output flagging odd transactions.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef MEMRSP_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  // Request copy captured on acceptance; used for the whole transaction.
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_wr;
  logic              r_oor;
  logic [31:0]       r_rdata;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_req;
  logic              w_in_oor;
  logic [IDX_W-1:0]  w_in_idx;
  logic              w_accept;
  logic              w_commit;
  logic [IDX_W-1:0]  w_c_idx;
  logic [31:0]       w_c_wdata;
  logic [3:0]        w_c_be;
  logic              w_c_wr;
  logic              w_c_oor;

  assign w_req    = mem_read | mem_write;
  // Any address bit above the word index makes the access out of range.
  assign w_in_oor = (mem_address >> (IDX_W + 2)) != 32'd0;
  assign w_in_idx = mem_address[IDX_W+1:2];
  assign w_accept = (r_state == IDLE) && w_req;

  // With LATENCY==1 the commit edge is also the acceptance edge, so the
  // commit operands come straight from the port while still in IDLE.
  assign w_c_idx   = (r_state == IDLE) ? w_in_idx        : r_idx;
  assign w_c_wdata = (r_state == IDLE) ? mem_wdata       : r_wdata;
  assign w_c_be    = (r_state == IDLE) ? mem_byte_enable : r_be;
  assign w_c_wr    = (r_state == IDLE) ? mem_write       : r_wr;
  assign w_c_oor   = (r_state == IDLE) ? w_in_oor        : r_oor;
  assign w_commit  = (w_next == RESP) && (r_state != RESP);

  assign mem_resp  = (r_state == RESP);
  assign mem_rdata = r_rdata;

  // Next-state and latency counter decode.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, counter, request latch and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx   <= w_in_idx;
        r_wdata <= mem_wdata;
        r_be    <= mem_byte_enable;
        r_wr    <= mem_write;
        r_oor   <= w_in_oor;
      end
      if (w_commit && !w_c_wr) begin
        r_rdata <= w_c_oor ? 32'd0 : r_mem[w_c_idx];
      end
    end
  end

  // Byte-lane write into the array on the commit edge; contents never reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_c_wr && !w_c_oor) begin
      for (int k = 0; k < 4; k++) begin
        if (w_c_be[k]) begin
          r_mem[w_c_idx][8*k +: 8] <= w_c_wdata[8*k +: 8];
        end
      end
    end
  end

`ifdef MEMRSP_ERR_EN
  logic r_err;

  // Flag odd requests at acceptance; reported only during the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_in_oor | (mem_read & mem_write) |
               (mem_write & (mem_byte_enable == 4'd0));
    end
  end

  assign mem_err = mem_resp & r_err;

`ifndef SYNTHESIS
  // Simulation notice for flagged transactions.
  always_ff @(posedge clk) begin
    if (rst_n && mem_err) begin
      $error("mem_responder: flagged transaction completed");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for mem_responder: three instances with LATENCY 1, 2 and 5.
// Inputs are driven 1ns after the rising edge and outputs sampled there too.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd_v    [3];
  logic        wr_v    [3];
  logic        resp_v  [3];
  logic [31:0] rdata_v [3];
`ifdef MEMRSP_ERR_EN
  logic        err_v   [3];
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat;
  logic [31:0] rdv;
  logic        last_err;
  int          pulses[$];

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_rdata(rdata_v[0]), .mem_resp(resp_v[0])
`ifdef MEMRSP_ERR_EN
    , .mem_err(err_v[0])
`endif
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_rdata(rdata_v[1]), .mem_resp(resp_v[1])
`ifdef MEMRSP_ERR_EN
    , .mem_err(err_v[1])
`endif
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(5)) u_dut_l5 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_v[2]), .mem_write(wr_v[2]),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_rdata(rdata_v[2]), .mem_resp(resp_v[2])
`ifdef MEMRSP_ERR_EN
    , .mem_err(err_v[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance d, held until mem_resp; returns the resp cycle
  // (-1 on timeout) and the rdata seen in it, then checks the pulse ends.
  task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     output int lat_o, output logic [31:0] rd_o);
    addr    = a;
    wdata   = wd;
    be      = b;
    rd_v[d] = r;
    wr_v[d] = w;
    lat_o   = -1;
    rd_o    = 32'hxxxxxxxx;
    last_err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (resp_v[d]) begin
        lat_o = c;
        rd_o  = rdata_v[d];
`ifdef MEMRSP_ERR_EN
        last_err = err_v[d];
`endif
        break;
      end
    end
    rd_v[d] = 1'b0;
    wr_v[d] = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, resp_v[d]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    be    = 4'd0;
    for (int d = 0; d < 3; d++) begin
      rd_v[d] = 1'b0;
      wr_v[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_resp", {31'd0, resp_v[d]}, 32'd0);
      chk("reset_rdata", rdata_v[d], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read, LATENCY=2.
    txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rdv);
    chk("wr_lat2", lat, 2);
    txn(1, 1, 0, 32'h10, 32'h0, 4'h0, lat, rdv);
    chk("rd_lat2", lat, 2);
    chk("rd_deadbeef", rdv, 32'hDEADBEEF);

    // Byte-lane merges.
    txn(1, 0, 1, 32'h20, 32'h11223344, 4'hF, lat, rdv);
    txn(1, 0, 1, 32'h20, 32'h0000AA00, 4'b0010, lat, rdv);
    txn(1, 1, 0, 32'h20, 32'h0, 4'h0, lat, rdv);
    chk("sb_merge", rdv, 32'h1122AA44);
    txn(1, 0, 1, 32'h22, 32'h55660000, 4'b1100, lat, rdv);
    txn(1, 1, 0, 32'h20, 32'h0, 4'h0, lat, rdv);
    chk("sh_merge", rdv, 32'h5566AA44);

    // LATENCY=1 and LATENCY=5 instances.
    txn(0, 0, 1, 32'h4, 32'hCAFEF00D, 4'hF, lat, rdv);
    chk("wr_lat1", lat, 1);
    txn(0, 1, 0, 32'h4, 32'h0, 4'h0, lat, rdv);
    chk("rd_lat1", lat, 1);
    chk("rd_lat1_data", rdv, 32'hCAFEF00D);
    txn(2, 0, 1, 32'h4, 32'h0F0F1234, 4'hF, lat, rdv);
    chk("wr_lat5", lat, 5);
    txn(2, 1, 0, 32'h4, 32'h0, 4'h0, lat, rdv);
    chk("rd_lat5", lat, 5);
    chk("rd_lat5_data", rdv, 32'h0F0F1234);

    // Back-to-back reads held high: pulses every LATENCY+1 cycles.
    pulses.delete();
    addr = 32'h10;
    rd_v[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (resp_v[1]) pulses.push_back(c);
      if (c == 8) rd_v[1] = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_l2_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk("b2b_l2_p0", pulses[0], 2);
      chk("b2b_l2_p1", pulses[1], 5);
      chk("b2b_l2_p2", pulses[2], 8);
    end
    pulses.delete();
    rd_v[2] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (resp_v[2]) pulses.push_back(c);
      if (c == 11) rd_v[2] = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_l5_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("b2b_l5_p0", pulses[0], 5);
      chk("b2b_l5_p1", pulses[1], 11);
    end

    // Address changed while waiting; request withdrawn early.
    txn(1, 0, 1, 32'h40, 32'h40404040, 4'hF, lat, rdv);
    txn(1, 0, 1, 32'h44, 32'h44444444, 4'hF, lat, rdv);
    addr = 32'h40;
    rd_v[1] = 1'b1;
    @(posedge clk); #1;
    addr = 32'h44;
    @(posedge clk); #1;
    chk("addr_chg_resp", {31'd0, resp_v[1]}, 32'd1);
    chk("addr_chg_data", rdata_v[1], 32'h40404040);
    rd_v[1] = 1'b0;
    @(posedge clk); #1;
    addr = 32'h44;
    rd_v[1] = 1'b1;
    @(posedge clk); #1;
    rd_v[1] = 1'b0;
    addr = 32'h0;
    @(posedge clk); #1;
    chk("withdrawn_resp", {31'd0, resp_v[1]}, 32'd1);
    chk("withdrawn_data", rdata_v[1], 32'h44444444);
    @(posedge clk); #1;

    // Out-of-range accesses alias nothing.
    txn(1, 0, 1, 32'h0, 32'h0BADC0DE, 4'hF, lat, rdv);
    txn(1, 1, 0, 32'h4000, 32'h0, 4'h0, lat, rdv);
    chk("oor_rd_lat", lat, 2);
    chk("oor_rd_data", rdv, 32'h0);
`ifdef MEMRSP_ERR_EN
    chk("oor_rd_err", {31'd0, last_err}, 32'd1);
`endif
    txn(1, 0, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, lat, rdv);
    chk("oor_wr_lat", lat, 2);
    chk("wr_keeps_rdata", rdv, 32'h0);
`ifdef MEMRSP_ERR_EN
    chk("oor_wr_err", {31'd0, last_err}, 32'd1);
`endif
    txn(1, 1, 0, 32'h0, 32'h0, 4'h0, lat, rdv);
    chk("oor_wr_dropped", rdv, 32'h0BADC0DE);

    // Read+write together acts as a write and leaves rdata alone.
    txn(1, 1, 1, 32'h10, 32'h12345678, 4'hF, lat, rdv);
    chk("rw_rdata_kept", rdv, 32'h0BADC0DE);
    txn(1, 1, 0, 32'h10, 32'h0, 4'h0, lat, rdv);
    chk("rw_is_write", rdv, 32'h12345678);

    // Zero byte enable write changes nothing.
    txn(1, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, rdv);
    chk("be0_lat", lat, 2);
    txn(1, 1, 0, 32'h10, 32'h0, 4'h0, lat, rdv);
    chk("be0_no_change", rdv, 32'h12345678);

    // Reset during WAIT of a write abandons it.
    txn(1, 0, 1, 32'h8, 32'h88888888, 4'hF, lat, rdv);
    addr = 32'h8;
    wdata = 32'h99999999;
    be = 4'hF;
    wr_v[1] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    wr_v[1] = 1'b0;
    #1;
    chk("rst_wait_resp", {31'd0, resp_v[1]}, 32'd0);
    chk("rst_wait_rdata", rdata_v[1], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 1, 0, 32'h8, 32'h0, 4'h0, lat, rdv);
    chk("rst_write_abandoned", rdv, 32'h88888888);

    // Asynchronous reset in the middle of the response cycle.
    addr = 32'h10;
    rd_v[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_resp", {31'd0, resp_v[1]}, 32'd1);
    rd_v[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_resp", {31'd0, resp_v[1]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
